// File: rtl/iter_cnt_pkg.sv
// Shared types for the iteration counter: operating modes, FSM states and mode decode.
package iter_cnt_pkg;

  typedef enum logic [1:0] {
    ONE_SHOT = 2'b00,
    AUTO_RLD = 2'b01,
    UP_TGT   = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // The unused encoding 2'b11 falls back to one-shot down counting.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return AUTO_RLD;
      2'b10:   return UP_TGT;
      default: return ONE_SHOT;
    endcase
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// One-cycle latency from inc to count, no backpressure.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/iter_cnt.sv
// Loadable iteration counter: one-shot down, auto-reload down and up-to-target modes.
// All outputs registered; one step per enabled cycle in RUN, no backpressure.
module iter_cnt
  import iter_cnt_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int RCW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [1:0]       mode,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             cnt_end,
  output logic             end_pulse,
  output logic [RCW-1:0]   reload_cnt
);

  state_e           state, nxt_state;
  mode_e            mode_q, nxt_mode;
  logic [WIDTH-1:0] rld, nxt_rld, nxt_out;
  logic             nxt_pulse, rc_clr, rc_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode_q    <= ONE_SHOT;
      rld       <= '0;
      out       <= '0;
      end_pulse <= 1'b0;
    end else begin
      state     <= nxt_state;
      mode_q    <= nxt_mode;
      rld       <= nxt_rld;
      out       <= nxt_out;
      end_pulse <= nxt_pulse;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_mode  = mode_q;
    nxt_rld   = rld;
    nxt_out   = out;
    nxt_pulse = 1'b0;
    rc_clr    = 1'b0;
    rc_inc    = 1'b0;
    if (clr) begin
      nxt_state = IDLE;
      nxt_out   = '0;
      rc_clr    = 1'b1;
    end else if (ld) begin
      nxt_rld   = ld_val;
      nxt_mode  = decode_mode(mode);
      nxt_out   = (decode_mode(mode) == UP_TGT) ? '0 : ld_val;
      nxt_state = (ld_val != '0) ? RUN : IDLE;
      rc_clr    = 1'b1;
    end else if ((state == RUN) && en) begin
      case (mode_q)
        AUTO_RLD: begin
          if (out > WIDTH'(1)) begin
            nxt_out = out - WIDTH'(1);
          end else begin
            nxt_out   = rld;
            nxt_pulse = 1'b1;
            rc_inc    = 1'b1;
          end
        end
        UP_TGT: begin
          // rld is non-zero whenever RUN is entered, so rld-1 cannot wrap.
          if (out != (rld - WIDTH'(1))) begin
            nxt_out = out + WIDTH'(1);
          end else begin
            nxt_out   = rld;
            nxt_pulse = 1'b1;
            nxt_state = DONE;
          end
        end
        default: begin
          if (out > WIDTH'(1)) begin
            nxt_out = out - WIDTH'(1);
          end else begin
            nxt_out   = '0;
            nxt_pulse = 1'b1;
            nxt_state = DONE;
          end
        end
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign cnt_end = (state == DONE);

  sat_cnt #(.W(RCW)) u_reload_cnt (
    .clk (clk),
    .rst (rst),
    .clr (rc_clr),
    .inc (rc_inc),
    .cnt (reload_cnt)
  );

endmodule

// File: tb/tb_iter_cnt.sv
// Bench for iter_cnt: directed scenarios then random stimulus against a step-count model.
module tb_iter_cnt;

  localparam int WIDTH  = 9;
  localparam int RCW    = 2;
  localparam int RC_MAX = (1 << RCW) - 1;

  logic             clk, rst, clr, ld, en;
  logic [WIDTH-1:0] ld_val;
  logic [1:0]       mode;
  logic [WIDTH-1:0] out;
  logic             busy, cnt_end, end_pulse;
  logic [RCW-1:0]   reload_cnt;

  iter_cnt #(.WIDTH(WIDTH), .RCW(RCW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .ld         (ld),
    .ld_val     (ld_val),
    .mode       (mode),
    .en         (en),
    .out        (out),
    .busy       (busy),
    .cnt_end    (cnt_end),
    .end_pulse  (end_pulse),
    .reload_cnt (reload_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: a loaded run is described by its length N, its mode and the number of
  // enabled steps taken since the load; every output is derived from those.
  int m_n, m_mode, m_steps;
  bit m_active, m_pulse;

  function automatic bit m_done();
    return m_active && (m_mode != 1) && (m_steps == m_n);
  endfunction

  function automatic int m_out();
    if (!m_active) return 0;
    case (m_mode)
      0:       return m_n - m_steps;
      1:       return m_n - (m_steps % m_n);
      default: return m_steps;
    endcase
  endfunction

  function automatic int m_rc();
    int p;
    if (!m_active || (m_mode != 1)) return 0;
    p = m_steps / m_n;
    return (p > RC_MAX) ? RC_MAX : p;
  endfunction

  task automatic model_reset();
    m_n = 0; m_mode = 0; m_steps = 0; m_active = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit c, input bit l, input int v, input int md, input bit e);
    m_pulse = 0;
    if (c) begin
      m_active = 0;
      m_steps  = 0;
    end else if (l) begin
      m_n      = v;
      m_mode   = (md == 3) ? 0 : md;
      m_steps  = 0;
      m_active = (v != 0);
    end else if (m_active && !m_done() && e) begin
      m_steps++;
      m_pulse = (m_mode == 1) ? ((m_steps % m_n) == 0) : (m_steps == m_n);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".out"},        32'(out),        32'(m_out()));
    chk({tag, ".busy"},       32'(busy),       32'(m_active && !m_done()));
    chk({tag, ".cnt_end"},    32'(cnt_end),    32'(m_done()));
    chk({tag, ".end_pulse"},  32'(end_pulse),  32'(m_pulse));
    chk({tag, ".reload_cnt"}, 32'(reload_cnt), 32'(m_rc()));
  endtask

  task automatic cyc(input string tag, input bit c, input bit l, input int v, input int md, input bit e);
    @(negedge clk);
    compare_all(tag);
    clr    = c;
    ld     = l;
    ld_val = v[WIDTH-1:0];
    mode   = md[1:0];
    en     = e;
    model_step(c, l, v, md, e);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; ld = 1'b0; ld_val = '0; mode = 2'b00; en = 1'b0;
    model_reset();
    #3;
    compare_all("reset");
    #9 rst = 1'b1;

    // Reset asserted mid-run must clear outputs without a clock edge.
    cyc("rst_mid", 0, 1, 8, 0, 0);
    repeat (3) cyc("rst_mid", 0, 0, 0, 0, 1);
    @(negedge clk);
    compare_all("pre_rst");
    chk("pre_rst.out5", 32'(out), 32'd5);
    clr = 1'b0; ld = 1'b0; en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst.out",  32'(out),        32'd0);
    chk("async_rst.busy", 32'(busy),       32'd0);
    chk("async_rst.end",  32'(cnt_end),    32'd0);
    chk("async_rst.puls", 32'(end_pulse),  32'd0);
    chk("async_rst.rc",   32'(reload_cnt), 32'd0);
    model_reset();
    @(negedge clk) rst = 1'b1;
    cyc("post_rst", 0, 0, 0, 0, 1);
    cyc("post_rst", 0, 0, 0, 0, 1);

    cyc("oneshot", 0, 1, 3, 0, 1);
    repeat (5) cyc("oneshot", 0, 0, 0, 0, 1);

    cyc("autorld", 0, 1, 4, 1, 1);
    repeat (20) cyc("autorld", 0, 0, 0, 0, 1);

    cyc("up", 0, 1, 3, 2, 1);
    cyc("up", 0, 0, 0, 0, 1);
    cyc("up", 0, 0, 0, 0, 0);
    cyc("up", 0, 0, 0, 0, 1);
    cyc("up", 0, 0, 0, 0, 0);
    cyc("up", 0, 0, 0, 0, 1);
    cyc("up", 0, 0, 0, 0, 1);
    cyc("up", 0, 0, 0, 0, 1);

    cyc("ld_zero", 0, 1, 0, 0, 1);
    cyc("ld_zero", 0, 0, 0, 0, 1);

    cyc("ld_term", 0, 1, 2, 0, 1);
    cyc("ld_term", 0, 0, 0, 0, 1);
    cyc("ld_term", 0, 1, 7, 0, 1);
    cyc("ld_term", 0, 0, 0, 0, 0);

    cyc("clr_ld", 0, 1, 5, 1, 1);
    cyc("clr_ld", 0, 0, 0, 0, 1);
    cyc("clr_ld", 1, 1, 9, 2, 1);
    cyc("clr_ld", 0, 0, 0, 0, 1);

    cyc("mode11", 0, 1, 2, 3, 1);
    repeat (4) cyc("mode11", 0, 0, 0, 0, 1);

    repeat (600)
      cyc("rand", ($urandom % 32) == 0, ($urandom % 8) == 0,
          int'($urandom_range(0, 12)), int'($urandom_range(0, 3)), ($urandom % 4) != 0);

    @(negedge clk);
    compare_all("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
